// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3 / double dabble).
// One conversion takes BIN_W shift cycles plus one DONE cycle. Results saturate
// to all nines when the input exceeds 10^DIGITS-1, and an optional mask flags
// leading-zero digits for display blanking.
module bin_to_bcd_seq #(
    parameter int BIN_W    = 14,
    parameter int DIGITS   = 4,
    parameter int LZ_BLANK = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank,
    output logic                  overflow
);

    localparam int                SW    = 4 * DIGITS;
    localparam int                CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(BIN_W - 1);
    localparam logic [SW-1:0]     ALL9  = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    // Working registers: binary shifter, scratch BCD, iteration count, sticky overflow
    logic [BIN_W-1:0]   r_bin;
    logic [SW-1:0]      r_scr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;

    // Held results, only updated on the edge that enters DONE
    logic [SW-1:0]      r_bcd;
    logic [DIGITS-1:0]  r_blank;
    logic               r_overflow;

    logic               w_accept;
    logic               w_last;
    logic [SW-1:0]      w_adj;
    logic [SW-1:0]      w_scr_sh;
    logic [BIN_W-1:0]   w_bin_sh;
    logic               w_ovf_sh;
    logic [DIGITS-1:0]  w_blank;

    assign ready    = (r_state == S_IDLE) || (r_state == S_DONE);
    assign busy     = (r_state == S_SHIFT);
    assign done     = (r_state == S_DONE);
    assign bcd      = r_bcd;
    assign blank    = r_blank;
    assign overflow = r_overflow;

    assign w_accept = start && ready;
    assign w_last   = (r_cnt == LAST);

    // Per-digit correction: a digit of 5..9 would become >=10 after doubling,
    // so pre-add 3 to make the shift carry into the next digit. No inter-digit carry.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign w_adj[4*gi +: 4] = (r_scr[4*gi +: 4] >= 4'd5) ?
                                      (r_scr[4*gi +: 4] + 4'd3) : r_scr[4*gi +: 4];
        end
    endgenerate

    // One double-dabble step: shift {scratch, binary} left; a 1 falling off the
    // top digit means the value no longer fits in DIGITS digits.
    assign w_scr_sh = {w_adj[SW-2:0], r_bin[BIN_W-1]};
    assign w_bin_sh = r_bin << 1;
    assign w_ovf_sh = r_ovf | w_adj[SW-1];

    // Leading-zero mask for the final scratch value; units digit never blanked
    always_comb begin
        logic w_zrun;
        w_blank = '0;
        w_zrun  = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            w_zrun     = w_zrun & (w_scr_sh[4*i +: 4] == 4'd0);
            w_blank[i] = w_zrun;
        end
        if ((LZ_BLANK == 0) || w_ovf_sh) begin
            w_blank = '0;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: IDLE/DONE accept a start, SHIFT runs BIN_W iterations
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = start ? S_SHIFT : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Working datapath: load on accept, otherwise step while shifting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bin <= '0;
            r_scr <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_bin <= bin;
            r_scr <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (r_state == S_SHIFT) begin
            r_bin <= w_bin_sh;
            r_scr <= w_scr_sh;
            r_ovf <= w_ovf_sh;
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Result registers: capture the final step straight from the shift path so
    // the outputs are valid during the DONE cycle, and hold otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bcd      <= '0;
            r_blank    <= '0;
            r_overflow <= 1'b0;
        end else if ((r_state == S_SHIFT) && w_last) begin
            r_bcd      <= w_ovf_sh ? ALL9 : w_scr_sh;
            r_blank    <= w_blank;
            r_overflow <= w_ovf_sh;
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq (BIN_W=14, DIGITS=4, LZ_BLANK=1): a cycle-level
// behavioural model checked every cycle, plus directed literal expectations.
module tb_bin_to_bcd_seq;

    localparam int BIN_W  = 14;
    localparam int DIGITS = 4;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic [13:0] bin   = '0;
    logic        ready, busy, done, overflow;
    logic [15:0] bcd;
    logic [3:0]  blank;

    int n_tests = 0;
    int n_fail  = 0;

    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS), .LZ_BLANK(1)) dut (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .ready(ready), .busy(busy), .done(done),
        .bcd(bcd), .blank(blank), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Expected results from plain decimal arithmetic
    function automatic logic [15:0] f_bcd(int v);
        if (v > 9999) return 16'h9999;
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [3:0] f_blank(int v);
        logic [3:0] b;
        b = '0;
        if (v > 9999) return b;
        for (int i = 1; i < DIGITS; i++) b[i] = (v < 10 ** i);
        return b;
    endfunction

    // Timing model: m_t counts edges since acceptance; result appears at BIN_W
    bit          m_act   = 1'b0;
    int          m_t     = 0;
    int          m_bin   = 0;
    logic [15:0] e_bcd   = '0;
    logic [3:0]  e_blank = '0;
    logic        e_ovf   = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_act   <= 1'b0;
            m_t     <= 0;
            e_bcd   <= '0;
            e_blank <= '0;
            e_ovf   <= 1'b0;
        end else begin
            if (m_act && m_t != BIN_W) begin
                m_t <= m_t + 1;
                if (m_t + 1 == BIN_W) begin
                    e_bcd   <= f_bcd(m_bin);
                    e_blank <= f_blank(m_bin);
                    e_ovf   <= (m_bin > 9999);
                end
            end else if (m_act) begin
                m_act <= 1'b0;
            end
            if ((!m_act || m_t == BIN_W) && start) begin
                m_act <= 1'b1;
                m_t   <= 0;
                m_bin <= int'(bin);
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        chk("done",     32'(done),     32'(m_act && m_t == BIN_W));
        chk("ready",    32'(ready),    32'(!m_act || m_t == BIN_W));
        chk("busy",     32'(busy),     32'(m_act && m_t < BIN_W));
        chk("bcd",      32'(bcd),      32'(e_bcd));
        chk("blank",    32'(blank),    32'(e_blank));
        chk("overflow", 32'(overflow), 32'(e_ovf));
    end

    task automatic timeout(string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: no done within cycle budget", name);
    endtask

    // Single conversion with literal expectations and start-to-done latency
    task automatic convert(int v, logic [15:0] eb, logic [3:0] ebl, logic eo);
        int c;
        bit seen;
        @(negedge clk);
        bin   = 14'(v);
        start = 1'b1;
        c     = 0;
        seen  = 1'b0;
        while (c < 60 && !seen) begin
            @(negedge clk);
            c++;
            start = 1'b0;
            seen  = done;
        end
        if (!seen) begin
            timeout("convert");
        end else begin
            chk("latency",      32'(c),        32'd15);
            chk("lit_bcd",      32'(bcd),      32'(eb));
            chk("lit_blank",    32'(blank),    32'(ebl));
            chk("lit_overflow", 32'(overflow), 32'(eo));
        end
    endtask

    initial begin
        int c, ndone, last, nxt;
        logic [15:0] got;
        repeat (2) @(negedge clk);
        chk("rst_bcd",   32'(bcd),   32'h0);
        chk("rst_ready", 32'(ready), 32'h1);
        chk("rst_done",  32'(done),  32'h0);
        rst = 1'b0;

        convert(9999,  16'h9999, 4'b0000, 1'b0);
        convert(31,    16'h0031, 4'b1100, 1'b0);
        convert(0,     16'h0000, 4'b1110, 1'b0);
        convert(16383, 16'h9999, 4'b0000, 1'b1);
        convert(2024,  16'h2024, 4'b0000, 1'b0);

        // Starts pulsed mid-conversion with another value must be ignored
        @(negedge clk);
        bin = 14'd1234; start = 1'b1;
        ndone = 0; got = '0; last = 0;
        for (c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = (c == 3 || c == 8);
            bin   = start ? 14'd777 : 14'd1234;
            if (done) begin ndone++; got = bcd; last = c; end
        end
        start = 1'b0;
        chk("noise_ndone",   32'(ndone), 32'd1);
        chk("noise_bcd",     32'(got),   32'h1234);
        chk("noise_latency", 32'(last),  32'd15);

        // Reset in the middle of a conversion
        @(negedge clk);
        bin = 14'd4321; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_ready", 32'(ready), 32'h1);
        chk("midrst_busy",  32'(busy),  32'h0);
        chk("midrst_bcd",   32'(bcd),   32'h0);
        chk("midrst_done",  32'(done),  32'h0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("midrst_nodone", 32'(ndone), 32'd0);
        convert(58, 16'h0058, 4'b1100, 1'b0);

        // Back-to-back: start held high, bin stepped at each done
        @(negedge clk);
        bin = 14'd0; start = 1'b1;
        nxt = 0; last = -1; ndone = 0;
        for (c = 1; c <= 20000; c++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (last >= 0) chk("b2b_gap", 32'(c - last), 32'd15);
                last = c;
                if (nxt == 1000) break;
                nxt++;
                bin = 14'(nxt);
            end
        end
        start = 1'b0;
        if (ndone != 1001) timeout("b2b");
        chk("b2b_last_bcd",   32'(bcd),   32'h1000);
        chk("b2b_last_blank", 32'(blank), 32'h0);
        repeat (20) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
